// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the pipeline stage-enable sequencer.
// Optional performance counters are enabled by defining STAGE_SEQUENCER_PERF_EN.
package stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    localparam logic STAGE_MODE_SEQUENTIAL = 1'b0;
    localparam logic STAGE_MODE_OVERLAPPED = 1'b1;

    localparam int DEFAULT_RAM_WE_STAGE = 4;
    localparam int DEFAULT_REG_WE_STAGE = 0;

    // HOLD leaves only once the hold counter is done; flush is honoured only in RUN.
    function automatic seq_state_e seq_next_state(
        input seq_state_e st,
        input logic       hold_done,
        input logic       flush
    );
        seq_state_e nxt;
        case (st)
            ST_HOLD:  nxt = hold_done ? ST_RUN : ST_HOLD;
            ST_RUN:   nxt = flush ? ST_FLUSH : ST_RUN;
            ST_FLUSH: nxt = ST_RUN;
            default:  nxt = ST_HOLD;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/stage_perf_counter.sv
// Free-running RUN-cycle and retired-slot counters, wrapping modulo 2^32.
// Instantiated by stage_sequencer only when STAGE_SEQUENCER_PERF_EN is defined.
module stage_perf_counter
    import stage_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        count_en,
    input  logic        retire_en,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count
);

    logic [31:0] cycle_count_q;
    logic [31:0] cycle_count_d;
    logic [31:0] retire_count_q;
    logic [31:0] retire_count_d;

    always_comb begin
        cycle_count_d  = cycle_count_q;
        retire_count_d = retire_count_q;
        if (count_en) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (retire_en) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_q  <= '0;
            retire_count_q <= '0;
        end else begin
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign cycle_count  = cycle_count_q;
    assign retire_count = retire_count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Stage-enable controller: one-hot token walk (sequential) or all-stage advance (overlapped),
// with stall, flush and post-reset hold. Counters exist only with STAGE_SEQUENCER_PERF_EN.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES        = 5,
    parameter int RAM_WE_STAGE      = DEFAULT_RAM_WE_STAGE,
    parameter int REG_WE_STAGE      = DEFAULT_REG_WE_STAGE,
    parameter int RESET_HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic                  stall_req,
    input  logic                  flush_req,
    output logic [NUM_STAGES-1:0] stage_write_enable,
    output logic                  ram_write_enable,
    output logic                  reg_write_enable,
    output logic                  pipeline_register_reset_n,
    output logic                  active_mode,
    output logic [31:0]           cycle_count,
    output logic [31:0]           retire_count
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] TOKEN_FIRST = NUM_STAGES'(1);

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic [HOLD_W-1:0]     hold_cnt_q;
    logic [HOLD_W-1:0]     hold_cnt_d;
    logic [NUM_STAGES-1:0] token_q;
    logic [NUM_STAGES-1:0] token_d;
    logic                  active_mode_q;
    logic                  active_mode_d;
    logic [NUM_STAGES-1:0] stage_en_q;
    logic [NUM_STAGES-1:0] stage_en_d;
    logic                  ram_en_q;
    logic                  ram_en_d;
    logic                  reg_en_q;
    logic                  reg_en_d;
    logic                  prr_n_q;
    logic                  prr_n_d;
    logic                  run_go;

    always_comb begin
        run_go        = (state_q == ST_RUN) && !stall_req;
        hold_cnt_d    = hold_cnt_q;
        token_d       = token_q;
        active_mode_d = active_mode_q;
        state_d       = seq_next_state(state_q, hold_cnt_q == HOLD_LAST, flush_req);

        if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        // Mode only switches at an instruction boundary (token at stage 0).
        if (run_go && token_q[0]) begin
            active_mode_d = mode;
        end

        // Overlapped mode, or a switch in either direction, parks the token at stage 0.
        if (run_go) begin
            if ((active_mode_q == STAGE_MODE_SEQUENTIAL) && (active_mode_d == STAGE_MODE_SEQUENTIAL)) begin
                token_d = {token_q[NUM_STAGES-2:0], token_q[NUM_STAGES-1]};
            end else begin
                token_d = TOKEN_FIRST;
            end
        end

        if (state_d == ST_FLUSH) begin
            token_d = TOKEN_FIRST;
        end

        // Enables are registered from next-state so the outputs carry no input path except stall.
        prr_n_d    = (state_d == ST_RUN);
        stage_en_d = '0;
        ram_en_d   = 1'b0;
        reg_en_d   = 1'b0;
        if (state_d == ST_RUN) begin
            if (active_mode_d == STAGE_MODE_OVERLAPPED) begin
                stage_en_d = '1;
                ram_en_d   = 1'b1;
                reg_en_d   = 1'b1;
            end else begin
                stage_en_d = token_d;
                ram_en_d   = token_d[RAM_WE_STAGE];
                reg_en_d   = token_d[REG_WE_STAGE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            token_q       <= TOKEN_FIRST;
            active_mode_q <= STAGE_MODE_SEQUENTIAL;
            stage_en_q    <= '0;
            ram_en_q      <= 1'b0;
            reg_en_q      <= 1'b0;
            prr_n_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            token_q       <= token_d;
            active_mode_q <= active_mode_d;
            stage_en_q    <= stage_en_d;
            ram_en_q      <= ram_en_d;
            reg_en_q      <= reg_en_d;
            prr_n_q       <= prr_n_d;
        end
    end

    assign stage_write_enable        = stall_req ? '0 : stage_en_q;
    assign ram_write_enable          = ram_en_q && !stall_req;
    assign reg_write_enable          = reg_en_q && !stall_req;
    assign pipeline_register_reset_n = prr_n_q;
    assign active_mode               = active_mode_q;

`ifdef STAGE_SEQUENCER_PERF_EN
    logic count_en;
    logic retire_en;

    // A slot retires on the sequential wrap out of the last stage, or every overlapped cycle.
    assign count_en  = run_go;
    assign retire_en = run_go &&
                       ((active_mode_q == STAGE_MODE_OVERLAPPED) || token_q[NUM_STAGES-1]);

    stage_perf_counter u_perf (
        .clk          (clk),
        .reset_n      (reset_n),
        .count_en     (count_en),
        .retire_en    (retire_en),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
    );
`else
    assign cycle_count  = '0;
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench: a 5-stage and a 3-stage sequencer driven by the same directed
// stimulus, checked every cycle against an integer-position model plus literal expectations.
module tb_stage_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    logic mode;
    logic stall_req;
    logic flush_req;

    logic [4:0]  sw5;
    logic        ram5, reg5, prr5, am5;
    logic [31:0] cc5, rc5;
    logic [2:0]  sw3;
    logic        ram3, reg3, prr3, am3;
    logic [31:0] cc3, rc3;

    int chk_cnt = 0;
    int err_cnt = 0;
    bit cmp_en  = 1'b0;

`ifdef STAGE_SEQUENCER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int RHC = 2;

    always #5 clk = ~clk;

    stage_sequencer #(
        .NUM_STAGES(5), .RAM_WE_STAGE(4), .REG_WE_STAGE(0), .RESET_HOLD_CYCLES(RHC)
    ) u_dut5 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .stall_req(stall_req), .flush_req(flush_req),
        .stage_write_enable(sw5), .ram_write_enable(ram5), .reg_write_enable(reg5),
        .pipeline_register_reset_n(prr5), .active_mode(am5),
        .cycle_count(cc5), .retire_count(rc5)
    );

    stage_sequencer #(
        .NUM_STAGES(3), .RAM_WE_STAGE(2), .REG_WE_STAGE(0), .RESET_HOLD_CYCLES(RHC)
    ) u_dut3 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .stall_req(stall_req), .flush_req(flush_req),
        .stage_write_enable(sw3), .ram_write_enable(ram3), .reg_write_enable(reg3),
        .pipeline_register_reset_n(prr3), .active_mode(am3),
        .cycle_count(cc3), .retire_count(rc3)
    );

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, exp, $time);
        end
    endtask

    function automatic int n_of(input int d);
        return (d == 0) ? 5 : 3;
    endfunction

    function automatic int ram_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    // Model: stage position as an integer, hold cycles remaining, pending flush cycle.
    int          m_hold [2] = '{RHC, RHC};
    int          m_pos  [2] = '{0, 0};
    bit          m_flush[2] = '{1'b0, 1'b0};
    bit          m_amode[2] = '{1'b0, 1'b0};
    int unsigned m_cyc  [2] = '{0, 0};
    int unsigned m_ret  [2] = '{0, 0};

    always @(posedge clk or negedge reset_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_hold[d] = RHC; m_pos[d] = 0; m_flush[d] = 1'b0;
                m_amode[d] = 1'b0; m_cyc[d] = 0; m_ret[d] = 0;
            end else if (m_hold[d] > 0) begin
                m_hold[d] = m_hold[d] - 1;
            end else if (m_flush[d]) begin
                m_flush[d] = 1'b0;
                m_pos[d]   = 0;
            end else begin
                if (!stall_req) begin
                    bit nm;
                    m_cyc[d] = m_cyc[d] + 1;
                    if (m_amode[d] || m_pos[d] == n_of(d) - 1) m_ret[d] = m_ret[d] + 1;
                    nm = (m_pos[d] == 0) ? mode : m_amode[d];
                    m_pos[d]   = (m_amode[d] || nm) ? 0 : (m_pos[d] + 1) % n_of(d);
                    m_amode[d] = nm;
                end
                if (flush_req) begin
                    m_flush[d] = 1'b1;
                    m_pos[d]   = 0;
                end
            end
        end
    end

    logic [31:0] g_sw, g_ram, g_reg, g_prr, g_am, g_cc, g_rc;
    logic [31:0] e_sw, e_ram, e_reg, e_prr;
    bit          e_run, e_go;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                g_sw  = (d == 0) ? {27'd0, sw5} : {29'd0, sw3};
                g_ram = {31'd0, (d == 0) ? ram5 : ram3};
                g_reg = {31'd0, (d == 0) ? reg5 : reg3};
                g_prr = {31'd0, (d == 0) ? prr5 : prr3};
                g_am  = {31'd0, (d == 0) ? am5 : am3};
                g_cc  = (d == 0) ? cc5 : cc3;
                g_rc  = (d == 0) ? rc5 : rc3;
                e_run = reset_n && (m_hold[d] == 0) && !m_flush[d];
                e_go  = e_run && !stall_req;
                e_sw  = !e_go ? 32'd0 : (m_amode[d] ? ((32'd1 << n_of(d)) - 1) : (32'd1 << m_pos[d]));
                e_ram = {31'd0, e_go && (m_amode[d] || m_pos[d] == ram_of(d))};
                e_reg = {31'd0, e_go && (m_amode[d] || m_pos[d] == 0)};
                e_prr = {31'd0, e_run};
                chk("cmp_stage_we", d, g_sw, e_sw);
                chk("cmp_ram_we", d, g_ram, e_ram);
                chk("cmp_reg_we", d, g_reg, e_reg);
                chk("cmp_prr_n", d, g_prr, e_prr);
                chk("cmp_active_mode", d, g_am, {31'd0, m_amode[d]});
                chk("cmp_cycle_count", d, g_cc, PERF ? m_cyc[d] : 32'd0);
                chk("cmp_retire_count", d, g_rc, PERF ? m_ret[d] : 32'd0);
            end
        end
    end

    task automatic cyc(input logic st, input logic fl, input logic md);
        @(posedge clk);
        #2;
        stall_req = st;
        flush_req = fl;
        mode      = md;
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        stall_req = 1'b0;
        flush_req = 1'b0;
        mode      = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_stage_we", 0, {27'd0, sw5}, 32'd0);
        chk("rst_prr_n", 0, {31'd0, prr5}, 32'd0);
        chk("rst_active_mode", 0, {31'd0, am5}, 32'd0);
        chk("rst_cycle_count", 0, cc5, 32'd0);

        // Reset release: two hold cycles, then the token walk.
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        chk("hold0_prr_n", 0, {31'd0, prr5}, 32'd0);
        cyc(0, 0, 0);
        chk("hold1_prr_n", 0, {31'd0, prr5}, 32'd0);
        chk("hold1_stage_we", 0, {27'd0, sw5}, 32'd0);
        cyc(0, 0, 0);
        chk("walk0_stage_we", 0, {27'd0, sw5}, 32'h01);
        chk("walk0_reg_we", 0, {31'd0, reg5}, 32'd1);
        chk("walk0_ram_we", 0, {31'd0, ram5}, 32'd0);
        chk("walk0_prr_n", 0, {31'd0, prr5}, 32'd1);
        chk("walk0_stage_we", 1, {29'd0, sw3}, 32'h1);
        cyc(0, 0, 0);
        chk("walk1_stage_we", 0, {27'd0, sw5}, 32'h02);
        chk("walk1_reg_we", 0, {31'd0, reg5}, 32'd0);
        chk("walk1_stage_we", 1, {29'd0, sw3}, 32'h2);
        cyc(0, 0, 0);
        chk("walk2_stage_we", 0, {27'd0, sw5}, 32'h04);
        chk("walk2_stage_we", 1, {29'd0, sw3}, 32'h4);
        chk("walk2_ram_we", 1, {31'd0, ram3}, 32'd1);
        cyc(0, 0, 0);
        chk("walk3_stage_we", 0, {27'd0, sw5}, 32'h08);
        chk("walk3_stage_we", 1, {29'd0, sw3}, 32'h1);
        cyc(0, 0, 0);
        chk("walk4_stage_we", 0, {27'd0, sw5}, 32'h10);
        chk("walk4_ram_we", 0, {31'd0, ram5}, 32'd1);
        cyc(0, 0, 0);
        chk("wrap_stage_we", 0, {27'd0, sw5}, 32'h01);
        chk("wrap_reg_we", 0, {31'd0, reg5}, 32'd1);
        cyc(0, 0, 0);
        chk("pre_stall_stage_we", 0, {27'd0, sw5}, 32'h02);

        // Stall at stage 2 for three cycles: zero-latency gating, token holds.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk("stall_stage_we", 0, {27'd0, sw5}, 32'h00);
            chk("stall_prr_n", 0, {31'd0, prr5}, 32'd1);
        end
        cyc(0, 0, 0);
        chk("unstall_stage_we", 0, {27'd0, sw5}, 32'h04);

        // Mode raised at stage 3: takes effect only after the token reaches stage 0.
        cyc(0, 0, 1);
        chk("mode_s3_stage_we", 0, {27'd0, sw5}, 32'h08);
        chk("mode_s3_active", 0, {31'd0, am5}, 32'd0);
        cyc(0, 0, 1);
        chk("mode_s4_active", 0, {31'd0, am5}, 32'd0);
        cyc(0, 0, 1);
        chk("mode_s0_stage_we", 0, {27'd0, sw5}, 32'h01);
        chk("mode_s0_active", 0, {31'd0, am5}, 32'd0);
        cyc(0, 0, 1);
        chk("ovl_stage_we", 0, {27'd0, sw5}, 32'h1f);
        chk("ovl_active", 0, {31'd0, am5}, 32'd1);
        chk("ovl_ram_we", 0, {31'd0, ram5}, 32'd1);
        cyc(0, 0, 1);
        chk("ovl2_stage_we", 0, {27'd0, sw5}, 32'h1f);

        // Back to sequential: restarts at stage 0.
        cyc(0, 0, 0);
        chk("seqback_stage_we", 0, {27'd0, sw5}, 32'h1f);
        cyc(0, 0, 0);
        chk("seqback0_stage_we", 0, {27'd0, sw5}, 32'h01);
        chk("seqback0_active", 0, {31'd0, am5}, 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("seqback2_stage_we", 0, {27'd0, sw5}, 32'h04);

        // Flush together with stall: one FLUSH cycle, then token at stage 0.
        cyc(1, 1, 0);
        chk("fs_stage_we", 0, {27'd0, sw5}, 32'h00);
        chk("fs_prr_n", 0, {31'd0, prr5}, 32'd1);
        cyc(0, 0, 0);
        chk("flush_prr_n", 0, {31'd0, prr5}, 32'd0);
        chk("flush_stage_we", 0, {27'd0, sw5}, 32'h00);
        cyc(0, 0, 0);
        chk("postflush_stage_we", 0, {27'd0, sw5}, 32'h01);
        chk("postflush_prr_n", 0, {31'd0, prr5}, 32'd1);
        cyc(0, 1, 0);
        chk("flush2_req_stage_we", 0, {27'd0, sw5}, 32'h02);
        cyc(0, 1, 0);
        chk("flush2_prr_n", 0, {31'd0, prr5}, 32'd0);
        cyc(0, 0, 0);
        chk("flush2_after_stage_we", 0, {27'd0, sw5}, 32'h01);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("pre_reset_stage_we", 0, {27'd0, sw5}, 32'h04);

        // Asynchronous reset mid-instruction, observed before the next clock edge.
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_stage_we", 0, {27'd0, sw5}, 32'h00);
        chk("async_rst_prr_n", 0, {31'd0, prr5}, 32'd0);
        chk("async_rst_cycle_count", 0, cc5, 32'd0);
        chk("async_rst_retire_count", 0, rc5, 32'd0);
        chk("async_rst_stage_we", 1, {29'd0, sw3}, 32'h0);
        repeat (2) @(negedge clk);

        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cyc((i % 7) == 3, i == 13, (i >= 8) && (i < 16));
        end
        chk("end_cycle_count", 1, cc3, PERF ? m_cyc[1] : 32'd0);
        chk("end_retire_count", 1, rc3, PERF ? m_ret[1] : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
